// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/retire sequencer: instruction layout,
// opcode and condition codes, flag bit positions and FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD      = 4'h0;
  localparam logic [3:0] OP_SUB      = 4'h1;
  localparam logic [3:0] OP_MUL      = 4'h2;
  localparam logic [3:0] OP_AND      = 4'h3;
  localparam logic [3:0] OP_OR       = 4'h4;
  localparam logic [3:0] OP_XOR      = 4'h5;
  localparam logic [3:0] OP_NOT      = 4'h6;
  localparam logic [3:0] OP_SHL      = 4'h7;
  localparam logic [3:0] OP_SHR      = 4'h8;
  localparam logic [3:0] OP_MOV      = 4'h9;
  localparam logic [3:0] OP_MOVI     = 4'hA;
  localparam logic [3:0] OP_SET_FLAG = 4'hB;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic        rsvd;
    logic [15:0] iv;
  } instr_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hC);
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// ARM-style condition check of a 4-bit cond code against the {N,Z,C,V} flags.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags_i[FLAG_N];
  assign z_s = flags_i[FLAG_Z];
  assign c_s = flags_i[FLAG_C];
  assign v_s = flags_i[FLAG_V];

  // condition decode
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z_s;
      COND_NE: pass_o = ~z_s;
      COND_CS: pass_o = c_s;
      COND_CC: pass_o = ~c_s;
      COND_MI: pass_o = n_s;
      COND_PL: pass_o = ~n_s;
      COND_VS: pass_o = v_s;
      COND_VC: pass_o = ~v_s;
      COND_HI: pass_o = c_s & ~z_s;
      COND_LS: pass_o = ~c_s | z_s;
      COND_GE: pass_o = (n_s == v_s);
      COND_LT: pass_o = (n_s != v_s);
      COND_GT: pass_o = ~z_s & (n_s == v_s);
      COND_LE: pass_o = z_s | (n_s != v_s);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire sequencer in front of a combinational ALU: latches one
// instruction, drives operands for its latency, then commits regfile/flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 2,
  parameter logic [31:0] REG_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_reg1,
  output logic [31:0] alu_reg2,
  output logic [15:0] alu_iv,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_cond,
  output logic        alu_s,
  output logic [3:0]  alu_flag,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_new_flag,
  output logic        retire_valid,
  output logic        retire_skip,
  output logic        illegal_op,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [3:0]  flags
);

  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

  state_e      state_q, state_d;
  instr_t      instr_q, instr_d;
  instr_t      instr_in_s;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  nflag_q, nflag_d;
  logic        pass_q, pass_d;
  logic [3:0]  flags_q;
  logic [31:0] regs_q [8];
  logic        cond_pass_s;
  logic        illegal_s;
  logic        in_wb_s;
  logic        reg_we_s;
  logic        flag_we_s;
  logic        unused_rsvd_s;

  assign instr_in_s    = instr_t'(instr);
  assign unused_rsvd_s = instr_q.rsvd;

  alu_cond_eval u_cond_eval (
    .cond_i  (instr_q.cond),
    .flags_i (flags_q),
    .pass_o  (cond_pass_s)
  );

  // FSM and EXEC-side capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      cnt_q   <= 4'd0;
      res_q   <= 32'd0;
      nflag_q <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      nflag_q <= nflag_d;
      pass_q  <= pass_d;
    end
  end

  // next-state: the counter covers multi-cycle MUL; capture on the last EXEC cycle
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    nflag_d = nflag_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr_in_s;
          cnt_d   = (instr_in_s.opcode == OP_MUL) ? MUL_LAT_C : 4'd1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q <= 4'd1) begin
          res_d   = alu_result;
          nflag_d = alu_new_flag;
          pass_d  = cond_pass_s;
          cnt_d   = 4'd0;
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Illegal opcodes bypass the condition entirely and never write state.
  assign illegal_s = is_illegal(instr_q.opcode);
  assign in_wb_s   = (state_q == ST_WB);
  assign reg_we_s  = in_wb_s & ~illegal_s & pass_q & (instr_q.opcode != OP_SET_FLAG);
  assign flag_we_s = in_wb_s & ~illegal_s & pass_q &
                     ((instr_q.opcode == OP_SET_FLAG) | instr_q.s);

  // architectural state commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= REG_RESET;
      end
      flags_q <= 4'b0000;
    end else begin
      if (reg_we_s) begin
        regs_q[instr_q.rd] <= res_q;
      end
      if (flag_we_s) begin
        flags_q <= nflag_q;
      end
    end
  end

  assign instr_ready  = (state_q == ST_IDLE);
  assign retire_valid = in_wb_s;
  assign retire_skip  = in_wb_s & ~illegal_s & ~pass_q;
  assign illegal_op   = in_wb_s & illegal_s;

  assign alu_reg1   = regs_q[instr_q.rd];
  assign alu_reg2   = regs_q[instr_q.rm];
  assign alu_iv     = instr_q.iv;
  assign alu_opcode = instr_q.opcode;
  assign alu_cond   = instr_q.cond;
  assign alu_s      = instr_q.s;
  assign alu_flag   = flags_q;
  assign flags      = flags_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU in the loop.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_reg1, alu_reg2;
  logic [15:0] alu_iv;
  logic [3:0]  alu_opcode, alu_cond, alu_flag;
  logic        alu_s;
  logic [31:0] alu_result;
  logic [3:0]  alu_new_flag;
  logic        retire_valid, retire_skip, illegal_op;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [3:0]  flags;

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .REG_RESET(32'd0)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_iv(alu_iv),
    .alu_opcode(alu_opcode), .alu_cond(alu_cond), .alu_s(alu_s), .alu_flag(alu_flag),
    .alu_result(alu_result), .alu_new_flag(alu_new_flag), .retire_valid(retire_valid),
    .retire_skip(retire_skip), .illegal_op(illegal_op), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // behavioural ALU; flags can be overridden to steer flag tests
  logic       ovr_en   = 1'b0;
  logic [3:0] ovr_flag = 4'd0;

  function automatic logic [31:0] alu_res_f(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] iv);
    case (op)
      OP_MUL:  return a * b;
      OP_MOVI: return {16'd0, iv};
      default: return a + b;
    endcase
  endfunction

  function automatic logic [3:0] alu_flag_f(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] iv,
                                            input logic oe, input logic [3:0] of);
    logic [32:0] sum;
    logic [31:0] r;
    if (oe) return of;
    r = alu_res_f(op, a, b, iv);
    if (op == OP_ADD) begin
      sum = {1'b0, a} + {1'b0, b};
      return {sum[31], (sum[31:0] == 32'd0), sum[32], (a[31] == b[31]) && (sum[31] != a[31])};
    end
    return {r[31], (r == 32'd0), 1'b0, 1'b0};
  endfunction

  always_comb begin
    alu_result   = alu_res_f(alu_opcode, alu_reg1, alu_reg2, alu_iv);
    alu_new_flag = alu_flag_f(alu_opcode, alu_reg1, alu_reg2, alu_iv, ovr_en, ovr_flag);
  end

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cf;         4'h3: return !cf;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cf && !z;   4'h9: return !cf || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op, input logic s,
                                     input logic [2:0] rd, input logic [2:0] rm, input logic [15:0] iv);
    return {c, op, s, rd, rm, 1'b0, iv};
  endfunction

  // reference architectural state and scoreboard
  logic [31:0] m_regs [8];
  logic [3:0]  m_flags;

  typedef struct {
    int   acc;
    int   lat;
    logic skip;
    logic ill;
  } exp_t;
  exp_t sb_q[$];

  task automatic push(input logic [31:0] w);
    exp_t e;
    logic [3:0] c, op;
    logic [2:0] rd, rm;
    logic [31:0] res;
    logic [3:0] nf;
    logic ok;
    c = w[31:28]; op = w[27:24]; rd = w[22:20]; rm = w[19:17];
    res = alu_res_f(op, m_regs[rd], m_regs[rm], w[15:0]);
    nf  = alu_flag_f(op, m_regs[rd], m_regs[rm], w[15:0], ovr_en, ovr_flag);
    ok  = cond_ok(c, m_flags);
    e.acc  = cyc;
    e.lat  = 1 + ((op == OP_MUL) ? MUL_LAT : 1);
    e.ill  = (op >= 4'hC);
    e.skip = !e.ill && !ok;
    if (!e.ill && ok) begin
      if (op == OP_SET_FLAG) m_flags = nf;
      else begin
        m_regs[rd] = res;
        if (w[23]) m_flags = nf;
      end
    end
    sb_q.push_back(e);
  endtask

  // retire monitor
  logic pulse_pend = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (pulse_pend) begin
      chk("retire_pulse_width", 32'(retire_valid), 32'd0);
      pulse_pend = 1'b0;
    end else if (retire_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_retire", 32'(retire_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("retire_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        chk("retire_skip", 32'(retire_skip), 32'(mon_e.skip));
        chk("illegal_op", 32'(illegal_op), 32'(mon_e.ill));
      end
      pulse_pend = 1'b1;
    end
  end

  task automatic issue(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(instr_ready), 32'd1);
    push(w);
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("reg_r%0d", i), dbg_data, m_regs[i]);
    end
    chk("flags", 32'(flags), 32'(m_flags));
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || pulse_pend) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (n >= 60) chk("retire_timeout", 32'(sb_q.size()), 32'd0);
    #1;
    check_state();
  endtask

  task automatic run(input logic [31:0] w);
    issue(w);
    instr_valid = 1'b0;
    wait_done();
  endtask

  task automatic peek(input string tag, input logic [2:0] r, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = r;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 3'd0;
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    m_flags = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_retire_valid", 32'(retire_valid), 32'd0);
    chk("rst_illegal_op", 32'(illegal_op), 32'd0);
    check_state();

    run(mk(COND_AL, OP_MOVI, 1'b0, 3'd1, 3'd0, 16'd5));
    run(mk(COND_AL, OP_MOVI, 1'b0, 3'd2, 3'd0, 16'd7) | 32'h0001_0000);
    run(mk(COND_AL, OP_ADD, 1'b1, 3'd1, 3'd2, 16'd0));
    peek("add_r1", 3'd1, 32'd12);
    chk("add_flags", 32'(flags), 32'd0);

    ovr_en = 1'b1; ovr_flag = 4'b1111;
    run(mk(COND_AL, OP_ADD, 1'b0, 3'd1, 3'd2, 16'd0));
    chk("add_s0_flags", 32'(flags), 32'd0);

    ovr_en = 1'b0;
    run(mk(COND_EQ, OP_ADD, 1'b1, 3'd1, 3'd2, 16'd0));
    peek("eq_skip_r1", 3'd1, 32'd19);

    ovr_en = 1'b1; ovr_flag = 4'b0100;
    run(mk(COND_AL, OP_SET_FLAG, 1'b0, 3'd0, 3'd0, 16'd0));
    ovr_en = 1'b0;
    run(mk(COND_EQ, OP_ADD, 1'b0, 3'd1, 3'd2, 16'd0));
    peek("eq_pass_r1", 3'd1, 32'd26);

    ovr_en = 1'b1; ovr_flag = 4'b1001;
    run(mk(COND_AL, OP_SET_FLAG, 1'b0, 3'd0, 3'd0, 16'd0));
    chk("set_flag", 32'(flags), 32'h9);
    ovr_flag = 4'b0110;
    run(mk(COND_AL, 4'hE, 1'b1, 3'd1, 3'd2, 16'd0));
    run(mk(COND_NV, 4'hF, 1'b1, 3'd2, 3'd1, 16'd0));
    ovr_en = 1'b0;
    run(mk(COND_LT, OP_ADD, 1'b0, 3'd2, 3'd2, 16'd0));
    run(mk(COND_GE, OP_MOVI, 1'b0, 3'd3, 3'd0, 16'd4));
    run(mk(COND_AL, OP_ADD, 1'b0, 3'd3, 3'd3, 16'd0));
    peek("rd_eq_rm_r3", 3'd3, 32'd8);

    run(mk(COND_AL, OP_MOVI, 1'b0, 3'd4, 3'd0, 16'd3));
    issue(mk(COND_AL, OP_MUL, 1'b0, 3'd4, 3'd2, 16'd0));
    instr = mk(COND_AL, OP_ADD, 1'b0, 3'd4, 3'd2, 16'd0);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_ready) break;
      low++;
    end
    chk("mul_ready_low_cycles", 32'(low), 32'd3);
    push(instr);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    wait_done();
    peek("mul_then_add_r4", 3'd4, 32'd28);

    issue(mk(COND_AL, OP_MUL, 1'b1, 3'd1, 3'd2, 16'd0));
    instr_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midexec_rst_ready", 32'(instr_ready), 32'd1);
    chk("midexec_rst_retire", 32'(retire_valid), 32'd0);
    chk("midexec_rst_flags", 32'(flags), 32'd0);
    dbg_addr = 3'd1;
    #1;
    chk("midexec_rst_r1", dbg_data, 32'd0);
    sb_q.delete();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    m_flags = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_state();
    run(mk(COND_AL, OP_MOVI, 1'b0, 3'd5, 3'd0, 16'd9));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
